// File: rtl/sh_seq_ctrl_pkg.sv
// Shared types and constants for the parallel-to-serial sequencer.
package sh_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Level driven on sout between words and shifted into the vacated register bits.
  localparam logic IDLE_LVL = 1'b1;

  // Width of a counter able to hold every value 0..w.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage : sh_seq_ctrl_pkg

// File: rtl/sh_core.sv
// W-bit right-shift register: load, shift-in at the MSB, synchronous reset to all ones.
module sh_core #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ld,
  input  logic         sh,
  input  logic         sh_in,
  input  logic [W-1:0] d,
  output logic         lsb
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Load has priority over shift.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (sh) begin
      q_d = {sh_in, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      q_q <= '1;
    end else begin
      q_q <= q_d;
    end
  end

  assign lsb = q_q[0];

endmodule : sh_core

// File: rtl/sh_seq_ctrl.sv
// Tick-paced parallel-to-serial sequencer: accepts a W-bit word in IDLE and
// drives it LSB first on sout, one bit per tick, then pulses done.
module sh_seq_ctrl
  import sh_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [W-1:0]          din,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic                  tick,
  output logic                  sout,
  output logic                  busy,
  output logic                  done,
  output logic [cnt_w(W)-1:0]   cnt
);

  localparam int unsigned CW = cnt_w(W);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sout_q, sout_d;
  logic            done_q, done_d;
  logic            ld_c;
  logic            sh_c;
  logic            core_lsb;

  sh_core #(
    .W (W)
  ) u_core (
    .clk   (clk),
    .rst_b (rst_b),
    .ld    (ld_c),
    .sh    (sh_c),
    .sh_in (IDLE_LVL),
    .d     (din),
    .lsb   (core_lsb)
  );

  // Next-state, register control and output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    ld_c    = 1'b0;
    sh_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (din_vld) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          ld_c    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          sout_d = core_lsb;
          sh_c   = 1'b1;
          cnt_d  = CW'(cnt_q + CW'(1));
          if (cnt_q == CW'(W - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Last data bit stays on sout until this tick closes its period.
        if (tick) begin
          sout_d  = IDLE_LVL;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sout_d  = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sout_q  <= IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign sout    = sout_q;
  assign done    = done_q;
  assign cnt     = cnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign din_rdy = (state_q == ST_IDLE) && rst_b;

endmodule : sh_seq_ctrl

// File: tb/tb_sh_seq_ctrl.sv
// Directed bench for sh_seq_ctrl (W=8): vector table plus multi-cycle sequences.
module tb_sh_seq_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_b;
  logic [W-1:0]  din;
  logic          din_vld;
  logic          din_rdy;
  logic          tick;
  logic          sout;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;

  sh_seq_ctrl #(
    .W (W)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .din     (din),
    .din_vld (din_vld),
    .din_rdy (din_rdy),
    .tick    (tick),
    .sout    (sout),
    .busy    (busy),
    .done    (done),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_b;
    logic          vld;
    logic [W-1:0]  din;
    logic          tick;
    logic          e_sout;
    logic          e_busy;
    logic          e_done;
    logic          e_rdy;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic v, input logic [W-1:0] d,
                              input logic t, input logic es, input logic eb,
                              input logic ed, input logic er, input int ec);
    vec_t x;
    x.rst_b = r;  x.vld = v;  x.din = d;  x.tick = t;
    x.e_sout = es; x.e_busy = eb; x.e_done = ed; x.e_rdy = er;
    x.e_cnt = CW'(ec);
    vq.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic es, input logic eb,
                         input logic ed, input logic er, input int ec);
    chk({nm, ".sout"}, 32'(sout), 32'(es));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".done"}, 32'(done), 32'(ed));
    chk({nm, ".rdy"},  32'(din_rdy), 32'(er));
    chk({nm, ".cnt"},  32'(cnt), 32'(ec));
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] pat;
    rst_b = 1'b0; din = '0; din_vld = 1'b0; tick = 1'b0;

    // Reset with din_vld asserted, then release.
    add(0, 1, 8'hA5, 1, 1, 0, 0, 0, 0);
    add(0, 1, 8'hA5, 1, 1, 0, 0, 0, 0);
    add(1, 0, 8'hA5, 1, 1, 0, 0, 1, 0);
    // Ticks in IDLE are ignored.
    for (int i = 0; i < 10; i++) add(1, 0, 8'h00, 1, 1, 0, 0, 1, 0);
    // 8'hA5 with tick every cycle: bits 1,0,1,0,0,1,0,1.
    add(1, 1, 8'hA5, 1, 1, 1, 0, 0, 0);
    add(1, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    add(1, 0, 8'h00, 1, 0, 1, 0, 0, 2);
    add(1, 0, 8'h00, 1, 1, 1, 0, 0, 3);
    add(1, 0, 8'h00, 1, 0, 1, 0, 0, 4);
    add(1, 0, 8'h00, 1, 0, 1, 0, 0, 5);
    add(1, 0, 8'h00, 1, 1, 1, 0, 0, 6);
    add(1, 0, 8'h00, 1, 0, 1, 0, 0, 7);
    add(1, 0, 8'h00, 1, 1, 1, 0, 0, 8);
    add(1, 0, 8'h00, 1, 1, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 1, 0, 0, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst_b = vq[i].rst_b; din_vld = vq[i].vld; din = vq[i].din; tick = vq[i].tick;
      step();
      chk_all($sformatf("v%0d", i), vq[i].e_sout, vq[i].e_busy, vq[i].e_done,
              vq[i].e_rdy, int'(vq[i].e_cnt));
    end

    // 8'h01 with tick every 3rd cycle: each bit held for 3 cycles.
    rst_b = 1'b1; din = 8'h01; din_vld = 1'b1; tick = 1'b0;
    step();
    chk_all("slow.ld", 1, 1, 0, 0, 0);
    din_vld = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      logic prev_bit;
      prev_bit = (t == 2) ? 1'b1 : ((t == 1) ? 1'b1 : 1'b0);
      for (int k = 0; k < 2; k++) begin
        tick = 1'b0;
        step();
        chk_all($sformatf("slow.t%0d.hold%0d", t, k), prev_bit, 1, 0, 0, t - 1);
      end
      tick = 1'b1;
      step();
      if (t < 9) chk_all($sformatf("slow.t%0d", t), (t == 1), 1, 0, 0, t);
      else       chk_all("slow.end", 1, 0, 1, 1, 0);
    end
    tick = 1'b0;
    step();
    chk_all("slow.after", 1, 0, 0, 1, 0);

    // 8'h0F in flight while 8'hFF is offered; 8'hFF taken on the done cycle.
    din = 8'h0F; din_vld = 1'b1; tick = 1'b1;
    step();
    chk_all("ovl.ld", 1, 1, 0, 0, 0);
    din = 8'hFF;
    pat = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("ovl.b%0d", i), pat[i], 1, 0, 0, i + 1);
    end
    step();
    chk_all("ovl.done", 1, 0, 1, 1, 0);
    step();
    chk_all("ovl.ld2", 1, 1, 0, 0, 0);
    din_vld = 1'b0; din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("ovl2.b%0d", i), 1, 1, 0, 0, i + 1);
    end
    step();
    chk_all("ovl2.done", 1, 0, 1, 1, 0);

    // Reset mid-word at cnt=4 aborts without a done pulse.
    din = 8'hA5; din_vld = 1'b1; tick = 1'b1;
    step();
    chk_all("abt.ld", 1, 1, 0, 0, 0);
    din_vld = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_all("abt.c4", 0, 1, 0, 0, 4);
    rst_b = 1'b0;
    step();
    chk_all("abt.rst", 1, 0, 0, 0, 0);
    rst_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_all($sformatf("abt.post%0d", i), 1, 0, 0, 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sh_seq_ctrl
